// File: rtl/mux8_1_dataflow_if.sv
// Bundle of the eight data inputs, select bits and mux outputs.
// No timing of its own: carries combinational and registered mux signals.
// No backpressure: the mux accepts every input every cycle.
interface mux8_1_dataflow_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] i0;
  logic [WIDTH-1:0] i1;
  logic [WIDTH-1:0] i2;
  logic [WIDTH-1:0] i3;
  logic [WIDTH-1:0] i4;
  logic [WIDTH-1:0] i5;
  logic [WIDTH-1:0] i6;
  logic [WIDTH-1:0] i7;
  logic             s0;
  logic             s1;
  logic             s2;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] y_q;
  logic [7:0]       sel_onehot;

  // Side that supplies data/select and observes the result.
  modport master (
    output i0, i1, i2, i3, i4, i5, i6, i7, s0, s1, s2,
    input  y, y_q, sel_onehot
  );

  // The multiplexer itself.
  modport slave (
    input  i0, i1, i2, i3, i4, i5, i6, i7, s0, s1, s2,
    output y, y_q, sel_onehot
  );
endinterface

// File: rtl/mux8_1_dataflow.sv
// 8-to-1 sum-of-products mux with one-hot select decode and a registered copy.
// Latency: y and sel_onehot are combinational; y_q lags y by one clk edge.
// Backpressure: none; a new selection is taken every cycle.
module mux8_1_dataflow #(
  parameter int WIDTH = 1
) (
  input logic                clk,
  input logic                rst,
  mux8_1_dataflow_if.slave   bus
);

  logic [2:0]       sel;
  logic [7:0]       minterm;
  logic [WIDTH-1:0] y_int;

  // s2 is the MSB of the select index.
  assign sel = {bus.s2, bus.s1, bus.s0};

  // One minterm per select code; together they cover all eight codes.
  assign minterm[0] = ~bus.s2 & ~bus.s1 & ~bus.s0;
  assign minterm[1] = ~bus.s2 & ~bus.s1 &  bus.s0;
  assign minterm[2] = ~bus.s2 &  bus.s1 & ~bus.s0;
  assign minterm[3] = ~bus.s2 &  bus.s1 &  bus.s0;
  assign minterm[4] =  bus.s2 & ~bus.s1 & ~bus.s0;
  assign minterm[5] =  bus.s2 & ~bus.s1 &  bus.s0;
  assign minterm[6] =  bus.s2 &  bus.s1 & ~bus.s0;
  assign minterm[7] =  bus.s2 &  bus.s1 &  bus.s0;

  // AND-OR network: each input gated by its minterm, then ORed together.
  assign y_int = ({WIDTH{minterm[0]}} & bus.i0)
               | ({WIDTH{minterm[1]}} & bus.i1)
               | ({WIDTH{minterm[2]}} & bus.i2)
               | ({WIDTH{minterm[3]}} & bus.i3)
               | ({WIDTH{minterm[4]}} & bus.i4)
               | ({WIDTH{minterm[5]}} & bus.i5)
               | ({WIDTH{minterm[6]}} & bus.i6)
               | ({WIDTH{minterm[7]}} & bus.i7);

  assign bus.y          = y_int;
  assign bus.sel_onehot = minterm;

  // Registered copy of y; synchronous reset wins over the load.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.y_q <= '0;
    end else begin
      bus.y_q <= y_int;
    end
  end

  // sel is kept as a readable index for debug views alongside the minterms.
  logic unused_sel;
  assign unused_sel = ^sel;

endmodule

// File: tb/tb_mux8_1_dataflow.sv
// Scoreboard bench for mux8_1_dataflow: a 1-bit and an 8-bit instance side by side.
// Stimulus pushes hand-computed expectations; a negedge monitor pops and compares.
// Inputs change 1 time unit after each rising edge.
module tb_mux8_1_dataflow;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mux8_1_dataflow_if #(.WIDTH(1)) bus1 ();
  mux8_1_dataflow_if #(.WIDTH(8)) bus8 ();

  mux8_1_dataflow #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  mux8_1_dataflow #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

  // Applied stimulus.
  logic [2:0] sel = 3'd0;
  logic [7:0] d1  = 8'h00;        // bit k drives bus1.ik
  logic [7:0] d8 [8];             // d8[k] drives bus8.ik
  // Staged stimulus, copied into d1/d8 just after an edge.
  logic [7:0] nxt_d1 = 8'h00;
  logic [7:0] nxt_d8 [8];

  assign bus1.s0 = sel[0];
  assign bus1.s1 = sel[1];
  assign bus1.s2 = sel[2];
  assign bus8.s0 = sel[0];
  assign bus8.s1 = sel[1];
  assign bus8.s2 = sel[2];
  assign bus1.i0 = d1[0];
  assign bus1.i1 = d1[1];
  assign bus1.i2 = d1[2];
  assign bus1.i3 = d1[3];
  assign bus1.i4 = d1[4];
  assign bus1.i5 = d1[5];
  assign bus1.i6 = d1[6];
  assign bus1.i7 = d1[7];
  assign bus8.i0 = d8[0];
  assign bus8.i1 = d8[1];
  assign bus8.i2 = d8[2];
  assign bus8.i3 = d8[3];
  assign bus8.i4 = d8[4];
  assign bus8.i5 = d8[5];
  assign bus8.i6 = d8[6];
  assign bus8.i7 = d8[7];

  // Scoreboard entries: kind selects which DUT output is compared.
  typedef struct packed {
    logic [2:0] kind;   // 0 y1, 1 onehot1, 2 y_q1, 3 y8, 4 y_q8, 5 onehot8
    logic [7:0] val;
  } exp_t;

  exp_t  sb_exp  [$];
  string sb_name [$];

  int n_chk  = 0;
  int n_fail = 0;

  // Expected y_q tracking: y_q after an edge is 0 under reset, else the
  // hand-computed y that was presented before that edge.
  logic       prev_e1 = 1'b0;
  logic [7:0] prev_e8 = 8'h00;

  task automatic push(input string name, input logic [2:0] kind, input logic [7:0] val);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    sb_exp.push_back(e);
    sb_name.push_back(name);
  endtask

  // One cycle: wait for an edge, apply new select/reset/data, queue expectations.
  task automatic step(input string tag, input logic [2:0] s, input logic r,
                      input logic e1, input logic [7:0] e8);
    logic       q1;
    logic [7:0] q8;
    @(posedge clk);
    q1 = rst ? 1'b0 : prev_e1;
    q8 = rst ? 8'h00 : prev_e8;
    #1;
    sel = s;
    rst = r;
    d1  = nxt_d1;
    for (int k = 0; k < 8; k++) d8[k] = nxt_d8[k];
    push({tag, "_y1"},  3'd0, {7'd0, e1});
    push({tag, "_oh1"}, 3'd1, 8'(8'd1 << s));
    push({tag, "_yq1"}, 3'd2, {7'd0, q1});
    push({tag, "_y8"},  3'd3, e8);
    push({tag, "_yq8"}, 3'd4, q8);
    push({tag, "_oh8"}, 3'd5, 8'(8'd1 << s));
    prev_e1 = e1;
    prev_e8 = e8;
  endtask

  // Monitor: on each falling edge compare everything queued for this cycle.
  always @(negedge clk) begin
    exp_t       e;
    string      nm;
    logic [7:0] act;
    while (sb_exp.size() > 0) begin
      e  = sb_exp.pop_front();
      nm = sb_name.pop_front();
      case (e.kind)
        3'd0:    act = {7'd0, bus1.y};
        3'd1:    act = bus1.sel_onehot;
        3'd2:    act = {7'd0, bus1.y_q};
        3'd3:    act = bus8.y;
        3'd4:    act = bus8.y_q;
        default: act = bus8.sel_onehot;
      endcase
      n_chk++;
      if (act !== e.val) begin
        n_fail++;
        $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, e.val, $time);
      end
    end
  end

  initial begin
    logic [7:0] pat;
    logic [2:0] s;
    for (int k = 0; k < 8; k++) begin
      d8[k]     = 8'h00;
      nxt_d8[k] = 8'h00;
    end

    // Reset held for two cycles: y_q is 0, y is 0 with all-zero data.
    step("rst_a", 3'd0, 1'b1, 1'b0, 8'h00);
    step("rst_b", 3'd0, 1'b1, 1'b0, 8'h00);

    // Registered path: only i5 set, sel=5; y immediate, y_q one edge later.
    nxt_d1    = 8'b0010_0000;
    nxt_d8[5] = 8'h01;
    step("reg_a", 3'd5, 1'b0, 1'b1, 8'h01);
    step("reg_b", 3'd5, 1'b0, 1'b1, 8'h01);
    // Reset raised between edges: y_q holds 1 until the next edge.
    step("mid_a", 3'd5, 1'b1, 1'b1, 8'h01);
    step("mid_b", 3'd5, 1'b1, 1'b1, 8'h01);
    step("mid_c", 3'd5, 1'b0, 1'b1, 8'h01);
    step("mid_d", 3'd5, 1'b0, 1'b1, 8'h01);

    // Sweep: alternating 0/1 on the 1-bit mux (y == s0); 8'h10+k on the wide one.
    nxt_d1 = 8'b1010_1010;
    for (int k = 0; k < 8; k++) nxt_d8[k] = 8'h10 + 8'(k);
    for (int k = 0; k < 8; k++) begin
      s = 3'(k);
      step("sweep", s, 1'b0, s[0], 8'h10 + 8'(k));
    end

    // Walking one on the 1-bit mux; wide mux keeps its 8'h10+sel pattern.
    for (int k = 0; k < 8; k++) begin
      nxt_d1 = 8'(8'd1 << k);
      for (int j = 0; j < 8; j++) begin
        s = 3'(j);
        step("walk", s, 1'b0, (j == k), 8'h10 + 8'(j));
      end
    end

    // Select glitch: new select and random wide data every cycle.
    pat    = 8'hA5;
    nxt_d1 = pat;
    for (int n = 0; n < 16; n++) begin
      for (int k = 0; k < 8; k++) nxt_d8[k] = 8'($urandom_range(0, 255));
      s = 3'($urandom_range(0, 7));
      step("glitch", s, 1'b0, pat[s], nxt_d8[s]);
    end

    // Final edge so the last presented y is checked at y_q.
    step("tail", sel, 1'b0, pat[sel], d8[sel]);

    // Drain the scoreboard with a bounded wait.
    for (int n = 0; n < 10 && sb_exp.size() > 0; n++) @(posedge clk);
    if (sb_exp.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb_exp.size());
    end
    @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
